// File: rtl/unidade_controle_drone.sv
// Drone game control unit: Moore FSM sequencing menu, move and collision check.
// Counts executed moves per game in db_jogadas.
module unidade_controle_drone #(
  parameter int JOGADAS_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic                 confirma,
  input  logic                 colisao,
  input  logic                 timeout,
  input  logic                 fim_mapa,
  input  logic                 borda_movimento,
  output logic                 zeraPosicoes,
  output logic                 resetaVidas,
  output logic                 zeraT,
  output logic                 contaT,
  output logic                 desloca,
  output logic                 escolhe_modo,
  output logic                 escolhe_vida,
  output logic                 escolhe_mapa,
  output logic                 checa_colisao,
  output logic                 atualiza,
  output logic                 pronto,
  output logic                 ganhou,
  output logic                 perdeu,
  output logic [3:0]           db_estado,
  output logic [JOGADAS_W-1:0] db_jogadas
);

  localparam logic [3:0] INICIAL       = 4'd0;
  localparam logic [3:0] PREPARA       = 4'd1;
  localparam logic [3:0] ESCOLHE_MODO  = 4'd2;
  localparam logic [3:0] ESCOLHE_VIDA  = 4'd3;
  localparam logic [3:0] ESCOLHE_MAPA  = 4'd4;
  localparam logic [3:0] INICIA_JOGADA = 4'd5;
  localparam logic [3:0] ESPERA_JOGADA = 4'd6;
  localparam logic [3:0] DESLOCA       = 4'd7;
  localparam logic [3:0] ESPERA_RAM    = 4'd8;
  localparam logic [3:0] CHECA         = 4'd9;
  localparam logic [3:0] REGISTRA      = 4'd10;
  localparam logic [3:0] COMPARA       = 4'd11;
  localparam logic [3:0] PERDEU        = 4'd12;
  localparam logic [3:0] GANHOU        = 4'd13;

  localparam logic [JOGADAS_W-1:0] JOG_MAX = '1;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       iniciar_d;
  logic       confirma_d;
  logic       iniciar_p;
  logic       confirma_p;

  assign iniciar_p  = iniciar & ~iniciar_d;
  assign confirma_p = confirma & ~confirma_d;

  // Delayed copies reset high so a button held through reset is not an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      iniciar_d  <= 1'b1;
      confirma_d <= 1'b1;
    end else begin
      iniciar_d  <= iniciar;
      confirma_d <= confirma;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INICIAL;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      db_jogadas <= '0;
    end else if (state == PREPARA) begin
      db_jogadas <= '0;
    end else if (state == DESLOCA && db_jogadas != JOG_MAX) begin
      db_jogadas <= db_jogadas + 1'b1;
    end
  end

  always_comb begin
    next_state = INICIAL;
    unique case (state)
      INICIAL:
        next_state = iniciar_p ? PREPARA : INICIAL;
      PREPARA:
        next_state = ESCOLHE_MODO;
      ESCOLHE_MODO:
        next_state = confirma_p ? ESCOLHE_VIDA : ESCOLHE_MODO;
      ESCOLHE_VIDA:
        next_state = confirma_p ? ESCOLHE_MAPA : ESCOLHE_VIDA;
      ESCOLHE_MAPA:
        next_state = confirma_p ? INICIA_JOGADA : ESCOLHE_MAPA;
      INICIA_JOGADA:
        next_state = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (timeout) begin
          next_state = PERDEU;
        end else if (borda_movimento) begin
          next_state = DESLOCA;
        end else begin
          next_state = ESPERA_JOGADA;
        end
      end
      DESLOCA:
        next_state = ESPERA_RAM;
      ESPERA_RAM:
        next_state = CHECA;
      CHECA:
        next_state = REGISTRA;
      REGISTRA:
        next_state = COMPARA;
      COMPARA: begin
        if (colisao) begin
          next_state = PERDEU;
        end else if (fim_mapa) begin
          next_state = GANHOU;
        end else begin
          next_state = INICIA_JOGADA;
        end
      end
      PERDEU:
        next_state = iniciar_p ? PREPARA : PERDEU;
      GANHOU:
        next_state = iniciar_p ? PREPARA : GANHOU;
      default:
        next_state = INICIAL;
    endcase
  end

  always_comb begin
    zeraPosicoes  = 1'b0;
    resetaVidas   = 1'b0;
    zeraT         = 1'b0;
    contaT        = 1'b0;
    desloca       = 1'b0;
    escolhe_modo  = 1'b0;
    escolhe_vida  = 1'b0;
    escolhe_mapa  = 1'b0;
    checa_colisao = 1'b0;
    atualiza      = 1'b0;
    pronto        = 1'b0;
    ganhou        = 1'b0;
    perdeu        = 1'b0;
    unique case (state)
      INICIAL, PREPARA: begin
        zeraPosicoes = 1'b1;
        resetaVidas  = 1'b1;
        zeraT        = 1'b1;
      end
      ESCOLHE_MODO:  escolhe_modo = 1'b1;
      ESCOLHE_VIDA:  escolhe_vida = 1'b1;
      ESCOLHE_MAPA:  escolhe_mapa = 1'b1;
      INICIA_JOGADA: zeraT = 1'b1;
      ESPERA_JOGADA: contaT = 1'b1;
      DESLOCA:       desloca = 1'b1;
      // Two-cycle window so the delayed collision pulse is still captured.
      CHECA, REGISTRA: begin
        atualiza      = 1'b1;
        checa_colisao = 1'b1;
      end
      PERDEU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state;

endmodule

// File: doc/unidade_controle_drone.md
UNIDADE_CONTROLE_DRONE -- requirements
Module: unidade_controle_drone

Interface
REQ-001 Parameter JOGADAS_W, default 8: width of the move counter db_jogadas.
REQ-002 Port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high.
REQ-004 Port iniciar, input, 1: start/restart request; level signal, edge-detected internally.
REQ-005 Port confirma, input, 1: menu confirm button; level signal, edge-detected internally.
REQ-006 Ports colisao, timeout, fim_mapa, borda_movimento, inputs, 1 each: status from the game datapath.
REQ-007 Ports zeraPosicoes, resetaVidas, zeraT, contaT, desloca, escolhe_modo, escolhe_vida, escolhe_mapa, checa_colisao, atualiza, outputs, 1 each: datapath controls, all active-high.
REQ-008 Ports pronto, ganhou, perdeu, outputs, 1 each: game finished / won / lost.
REQ-009 Port db_estado, output, 4: current state code.
REQ-010 Port db_jogadas, output, JOGADAS_W: moves executed in the current game.

Function
REQ-011 Moore FSM; all outputs decoded from the registered state only, except db_jogadas (a register).
REQ-012 States and codes: INICIAL=0, PREPARA=1, ESCOLHE_MODO=2, ESCOLHE_VIDA=3, ESCOLHE_MAPA=4, INICIA_JOGADA=5, ESPERA_JOGADA=6, DESLOCA=7, ESPERA_RAM=8, CHECA=9, REGISTRA=10, COMPARA=11, PERDEU=12, GANHOU=13; codes 14-15 go to INICIAL on the next clock.
REQ-013 Edge detection: iniciar_p = iniciar & ~iniciar_d and confirma_p = confirma & ~confirma_d, with iniciar_d/confirma_d registered each clock; only these pulses advance the FSM.
REQ-014 INICIAL: zeraPosicoes=resetaVidas=zeraT=1; iniciar_p -> PREPARA.
REQ-015 PREPARA: zeraPosicoes=resetaVidas=zeraT=1; db_jogadas cleared to 0; unconditional -> ESCOLHE_MODO.
REQ-016 ESCOLHE_MODO / ESCOLHE_VIDA / ESCOLHE_MAPA: assert escolhe_modo / escolhe_vida / escolhe_mapa respectively; confirma_p advances to the next state in that order; ESCOLHE_MAPA -> INICIA_JOGADA.
REQ-017 INICIA_JOGADA: zeraT=1 for one cycle; -> ESPERA_JOGADA.
REQ-018 ESPERA_JOGADA: contaT=1. timeout=1 -> PERDEU, taking priority over a simultaneous borda_movimento; otherwise borda_movimento=1 -> DESLOCA; otherwise stay.
REQ-019 DESLOCA: desloca=1 for exactly one cycle; db_jogadas increments, saturating at all-ones; -> ESPERA_RAM.
REQ-020 ESPERA_RAM: no controls asserted; one cycle covering the synchronous map RAM read latency; -> CHECA.
REQ-021 CHECA and REGISTRA: atualiza=1 and checa_colisao=1 in both states, so the collision-pulse edge detector (one cycle later) lands inside the counter enable window; CHECA -> REGISTRA -> COMPARA.
REQ-022 COMPARA: colisao=1 -> PERDEU; else fim_mapa=1 -> GANHOU; else -> INICIA_JOGADA. colisao has priority over a simultaneous fim_mapa.
REQ-023 PERDEU: pronto=1, perdeu=1. GANHOU: pronto=1, ganhou=1. Both hold until iniciar_p -> PREPARA; db_jogadas holds its final value.
REQ-024 Outputs not listed for a state are 0 in that state.
REQ-025 Holding iniciar or confirma high never causes more than one transition.

Reset
REQ-026 reset=1 on a clock edge forces INICIAL, db_jogadas=0 and iniciar_d=confirma_d=1; this suppresses a false edge from a held button. reset overrides every other input, in any state, including mid-move.
REQ-027 After reset, outputs are those of INICIAL: zeraPosicoes=resetaVidas=zeraT=1, all others 0, db_estado=0.

Verification
REQ-028 Reset, then pulse iniciar, then three confirma pulses -> db_estado sequence 0,1,2,3,4,5,6; escolhe_* each high only in its own state.
REQ-029 In ESPERA_JOGADA, pulse borda_movimento with colisao=0 and fim_mapa=0 -> desloca high for 1 cycle; states 7,8,9,10,11,5,6; db_jogadas=1; atualiza/checa_colisao high exactly 2 cycles.
REQ-030 Same as REQ-029 but colisao=1 in COMPARA -> PERDEU (12); pronto=perdeu=1, ganhou=0; iniciar_p -> PREPARA with db_jogadas=0.
REQ-031 fim_mapa=1 and colisao=1 in the same COMPARA cycle -> PERDEU. fim_mapa=1 alone -> GANHOU (13), ganhou=1.
REQ-032 timeout and borda_movimento asserted together in ESPERA_JOGADA -> PERDEU; desloca never asserted.
REQ-033 iniciar held high through reset and for 10 cycles -> FSM stays in INICIAL. Assert reset in REGISTRA -> db_estado=0 on the next cycle and db_jogadas=0.
